// File: rtl/id_stage_if.sv
// -----------------------------------------------------------------------------
// id_stage_if
//   Bundles every non-clock/reset signal between the IF/ID register, the
//   write-back path, the hazard sources in EX/MEM and the ID/EX register.
//
//   slave  modport : used by id_stage (decode stage itself)
//   master modport : used by whatever drives the stage (pipeline or bench)
//
//   Inputs to the stage : instr, pc_plus4, wb_* write-back port,
//                         id_ex_* / ex_* / ex_mem_* hazard sources
//   Outputs of the stage: ID/EX control bits, operands, immediate, register
//                         fields, pc_write / if_id_write / if_id_flush,
//                         branch_taken / branch_target
// -----------------------------------------------------------------------------
interface id_stage_if #(
  parameter int WORD_W = 32
);
  logic [31:0]       instr;
  logic [WORD_W-1:0] pc_plus4;
  logic              wb_reg_write;
  logic [4:0]        wb_write_reg;
  logic [WORD_W-1:0] wb_write_data;
  logic              id_ex_mem_read;
  logic              id_ex_reg_write;
  logic [4:0]        ex_write_reg;
  logic              ex_mem_mem_read;
  logic [4:0]        ex_mem_write_reg;

  logic              mem_write;
  logic              mem_read;
  logic              reg_write;
  logic              reg_dst;
  logic              mem_to_reg;
  logic              ALU_src;
  logic [2:0]        ALU_op;
  logic [WORD_W-1:0] read_data1;
  logic [WORD_W-1:0] read_data2;
  logic [WORD_W-1:0] instr15_0_sign_extended;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              branch_taken;
  logic [WORD_W-1:0] branch_target;

  modport slave (
    input  instr, pc_plus4, wb_reg_write, wb_write_reg, wb_write_data,
           id_ex_mem_read, id_ex_reg_write, ex_write_reg,
           ex_mem_mem_read, ex_mem_write_reg,
    output mem_write, mem_read, reg_write, reg_dst, mem_to_reg, ALU_src,
           ALU_op, read_data1, read_data2, instr15_0_sign_extended,
           rs, rt, rd, pc_write, if_id_write, if_id_flush,
           branch_taken, branch_target
  );

  modport master (
    output instr, pc_plus4, wb_reg_write, wb_write_reg, wb_write_data,
           id_ex_mem_read, id_ex_reg_write, ex_write_reg,
           ex_mem_mem_read, ex_mem_write_reg,
    input  mem_write, mem_read, reg_write, reg_dst, mem_to_reg, ALU_src,
           ALU_op, read_data1, read_data2, instr15_0_sign_extended,
           rs, rt, rd, pc_write, if_id_write, if_id_flush,
           branch_taken, branch_target
  );
endinterface

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
//   Instruction-decode stage of a 5-stage MIPS pipeline. Holds the register
//   file (with same-cycle write-back bypass), decodes control, sign-extends
//   the immediate, resolves beq in ID and generates stall / flush controls.
//
//   clk   : rising-edge clock
//   rst   : synchronous, active-low reset (clears the register file)
//   id_if : id_stage_if.slave bundle, see rtl/id_stage_if.sv
// -----------------------------------------------------------------------------
module id_stage #(
  parameter int REG_COUNT = 32,
  parameter int WORD_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  id_stage_if.slave   id_if
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  // ---------------------------------------------------------------- fields
  logic [5:0] opcode;
  logic [4:0] rs_f, rt_f, rd_f;

  assign opcode = id_if.instr[31:26];
  assign rs_f   = id_if.instr[25:21];
  assign rt_f   = id_if.instr[20:16];
  assign rd_f   = id_if.instr[15:11];

  // --------------------------------------------------------- register file
  // Flip-flop array rather than RAM: the whole file must clear in one cycle
  // and both read ports are combinational.
  logic [WORD_W-1:0] regs_q [REG_COUNT];
  logic [WORD_W-1:0] regs_d [REG_COUNT];
  logic              wb_en;

  assign wb_en     = id_if.wb_reg_write && (id_if.wb_write_reg != 5'd0);
  assign regs_d[0] = '0;

  generate
    for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_reg
      assign regs_d[gi] = (wb_en && (id_if.wb_write_reg == 5'(gi)))
                          ? id_if.wb_write_data : regs_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Write-back data that lands this edge is forwarded to the readers now.
  logic [WORD_W-1:0] rd1, rd2;
  assign rd1 = (wb_en && (id_if.wb_write_reg == rs_f)) ? id_if.wb_write_data : regs_q[rs_f];
  assign rd2 = (wb_en && (id_if.wb_write_reg == rt_f)) ? id_if.wb_write_data : regs_q[rt_f];

  // ---------------------------------------------------------------- decode
  logic       dec_mem_write, dec_mem_read, dec_reg_write, dec_reg_dst;
  logic       dec_mem_to_reg, dec_alu_src, is_beq, reads_rt;
  logic [2:0] dec_alu_op;

  always_comb begin
    dec_mem_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_reg_write  = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_alu_op     = 3'b000;
    is_beq         = 1'b0;
    reads_rt       = 1'b0;
    case (opcode)
      OP_R: begin
        dec_reg_dst   = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_op    = 3'b010;
        reads_rt      = 1'b1;
      end
      OP_LW: begin
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_reg_write  = 1'b1;
      end
      OP_SW: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        reads_rt      = 1'b1;
      end
      OP_ADDI: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_ANDI: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_op    = 3'b011;
      end
      OP_BEQ: begin
        dec_alu_op = 3'b001;
        is_beq     = 1'b1;
        reads_rt   = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------- hazards
  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
  logic load_use, branch_hazard, stall, active;

  assign ex_rs_hit  = (id_if.ex_write_reg != 5'd0) && (id_if.ex_write_reg == rs_f);
  assign ex_rt_hit  = (id_if.ex_write_reg != 5'd0) && (id_if.ex_write_reg == rt_f);
  assign mem_rs_hit = (id_if.ex_mem_write_reg != 5'd0) && (id_if.ex_mem_write_reg == rs_f);
  assign mem_rt_hit = (id_if.ex_mem_write_reg != 5'd0) && (id_if.ex_mem_write_reg == rt_f);

  assign load_use = id_if.id_ex_mem_read && (ex_rs_hit || (reads_rt && ex_rt_hit));

  // beq compares in ID, so it must also wait for any ALU result still in EX
  // and for a load that has only reached MEM.
  assign branch_hazard = is_beq &&
                         ((id_if.id_ex_reg_write && (ex_rs_hit || ex_rt_hit)) ||
                          (id_if.ex_mem_mem_read && (mem_rs_hit || mem_rt_hit)));

  // Reset masks the stall so the front end keeps flowing while in reset.
  assign stall  = rst && (load_use || branch_hazard);
  assign active = rst && !stall;

  // --------------------------------------------------------------- outputs
  logic [WORD_W-1:0] imm_ext;
  assign imm_ext = {{(WORD_W-16){id_if.instr[15]}}, id_if.instr[15:0]};

  assign id_if.mem_write  = active && dec_mem_write;
  assign id_if.mem_read   = active && dec_mem_read;
  assign id_if.reg_write  = active && dec_reg_write;
  assign id_if.reg_dst    = active && dec_reg_dst;
  assign id_if.mem_to_reg = active && dec_mem_to_reg;
  assign id_if.ALU_src    = active && dec_alu_src;
  assign id_if.ALU_op     = active ? dec_alu_op : 3'b000;

  assign id_if.read_data1              = rd1;
  assign id_if.read_data2              = rd2;
  assign id_if.instr15_0_sign_extended = imm_ext;
  assign id_if.rs                      = rs_f;
  assign id_if.rt                      = rt_f;
  assign id_if.rd                      = rd_f;

  assign id_if.pc_write      = !stall;
  assign id_if.if_id_write   = !stall;
  assign id_if.branch_taken  = active && is_beq && (rd1 == rd2);
  assign id_if.if_id_flush   = id_if.branch_taken;
  assign id_if.branch_target = id_if.pc_plus4 + (imm_ext << 2);

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
//   Self-checking bench for id_stage: directed scenarios followed by random
//   stimulus, every cycle compared against a behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_id_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if #(.WORD_W(32)) bus ();

  id_stage #(.REG_COUNT(32), .WORD_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .id_if (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Architectural register contents as the model sees them.
  logic [31:0] mregs [32];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int s, input int t, input int d);
    return {6'h00, 5'(s), 5'(t), 5'(d), 11'h020};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int s, input int t,
                                        input logic [15:0] imm);
    return {op, 5'(s), 5'(t), imm};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (bus.wb_reg_write && bus.wb_write_reg == r) return bus.wb_write_data;
    return mregs[r];
  endfunction

  task automatic set_idle();
    rst                  = 1'b1;
    bus.instr            = 32'd0;
    bus.pc_plus4         = 32'd0;
    bus.wb_reg_write     = 1'b0;
    bus.wb_write_reg     = 5'd0;
    bus.wb_write_data    = 32'd0;
    bus.id_ex_mem_read   = 1'b0;
    bus.id_ex_reg_write  = 1'b0;
    bus.ex_write_reg     = 5'd0;
    bus.ex_mem_mem_read  = 1'b0;
    bus.ex_mem_write_reg = 5'd0;
  endtask

  // Compare every output against the model; called mid-cycle after inputs settle.
  task automatic settle(input string tag);
    logic [5:0]  op;
    logic [4:0]  s, t, d, ex, exm;
    logic [31:0] a, b, imm;
    logic [8:0]  ctl, got_ctl;
    bit          uses_rt, is_beq, lu, bh, stall, taken;
    #1;
    op  = bus.instr[31:26];
    s   = bus.instr[25:21];
    t   = bus.instr[20:16];
    d   = bus.instr[15:11];
    ex  = bus.ex_write_reg;
    exm = bus.ex_mem_write_reg;
    a   = model_read(s);
    b   = model_read(t);
    uses_rt = 1'b0;
    // {mem_write, mem_read, reg_write, reg_dst, mem_to_reg, ALU_src, ALU_op}
    case (op)
      6'b000000: begin ctl = 9'b001100_010; uses_rt = 1'b1; end
      6'b100011: ctl = 9'b011011_000;
      6'b101011: begin ctl = 9'b100001_000; uses_rt = 1'b1; end
      6'b001000: ctl = 9'b001001_000;
      6'b001100: ctl = 9'b001001_011;
      6'b000100: begin ctl = 9'b000000_001; uses_rt = 1'b1; end
      default:   ctl = 9'd0;
    endcase
    is_beq = (op == 6'b000100);
    lu = bus.id_ex_mem_read && ex != 0 && (ex == s || (uses_rt && ex == t));
    bh = is_beq && ((bus.id_ex_reg_write && ex != 0 && (ex == s || ex == t)) ||
                    (bus.ex_mem_mem_read && exm != 0 && (exm == s || exm == t)));
    stall = rst && (lu || bh);
    if (!rst || stall) ctl = 9'd0;
    taken = rst && !stall && is_beq && (a == b);
    imm   = {{16{bus.instr[15]}}, bus.instr[15:0]};

    got_ctl = {bus.mem_write, bus.mem_read, bus.reg_write, bus.reg_dst,
               bus.mem_to_reg, bus.ALU_src, bus.ALU_op};
    check_eq({tag, "/ctl"}, 32'(got_ctl), 32'(ctl));
    check_eq({tag, "/flow"},
             32'({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.branch_taken}),
             32'({!stall, !stall, taken, taken}));
    check_eq({tag, "/fields"}, 32'({bus.rs, bus.rt, bus.rd}), 32'({s, t, d}));
    check_eq({tag, "/imm"}, bus.instr15_0_sign_extended, imm);
    check_eq({tag, "/target"}, bus.branch_target, bus.pc_plus4 + (imm << 2));
    if (rst && !stall) begin
      check_eq({tag, "/rd1"}, bus.read_data1, a);
      check_eq({tag, "/rd2"}, bus.read_data2, b);
    end
    $display("cyc %0d %s rst=%b instr=%08h rd1=%08h rd2=%08h pc_write=%b taken=%b",
             cyc, tag, rst, bus.instr, bus.read_data1, bus.read_data2,
             bus.pc_write, bus.branch_taken);
  endtask

  // Clock edge: model the register file update, then return to the negedge.
  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else if (bus.wb_reg_write && bus.wb_write_reg != 5'd0) begin
      mregs[bus.wb_write_reg] = bus.wb_write_data;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic write_reg(input int r, input logic [31:0] v);
    set_idle();
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_reg  = 5'(r);
    bus.wb_write_data = v;
    settle("wr");
    advance();
  endtask

  initial begin
    logic [5:0] op;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    set_idle();
    rst = 1'b0;
    @(negedge clk);

    // Reset with a competing write-back: reset wins, controls stay 0.
    bus.instr         = rtype(5, 6, 1);
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_reg  = 5'd5;
    bus.wb_write_data = 32'hAAAA_AAAA;
    settle("rst");
    check_eq("rst_pc_write", 32'(bus.pc_write), 32'd1);
    advance();
    set_idle();
    bus.instr = rtype(5, 6, 1);
    settle("rst_rd");
    check_eq("rst_rd1", bus.read_data1, 32'd0);
    advance();

    // Fill $5/$6, reset again, confirm cleared.
    write_reg(5, 32'h55);
    write_reg(6, 32'h66);
    set_idle();
    rst = 1'b0;
    settle("rst2");
    advance();
    set_idle();
    bus.instr = rtype(5, 6, 1);
    settle("rst2_rd");
    check_eq("rst2_rd2", bus.read_data2, 32'd0);
    advance();

    // $0 stays zero.
    set_idle();
    bus.instr         = rtype(0, 0, 1);
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_reg  = 5'd0;
    bus.wb_write_data = 32'hFFFF_FFFF;
    settle("r0_wr");
    check_eq("r0_bypass", bus.read_data1, 32'd0);
    advance();
    set_idle();
    bus.instr = rtype(0, 0, 1);
    settle("r0_rd");
    check_eq("r0_read", bus.read_data1, 32'd0);
    advance();

    // Write-back bypass, then retained value.
    set_idle();
    bus.instr         = rtype(7, 0, 2);
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_reg  = 5'd7;
    bus.wb_write_data = 32'h1234_5678;
    settle("byp");
    check_eq("byp_rd1", bus.read_data1, 32'h1234_5678);
    advance();
    set_idle();
    bus.instr = rtype(7, 0, 2);
    settle("byp_keep");
    check_eq("byp_keep_rd1", bus.read_data1, 32'h1234_5678);
    advance();

    // Load-use stall then release.
    set_idle();
    bus.instr          = rtype(8, 9, 10);
    bus.id_ex_mem_read = 1'b1;
    bus.ex_write_reg   = 5'd8;
    settle("lu");
    check_eq("lu_pc_write", 32'(bus.pc_write), 32'd0);
    check_eq("lu_ctl", 32'({bus.reg_write, bus.ALU_op}), 32'b0_000);
    advance();
    bus.id_ex_mem_read = 1'b0;
    settle("lu_rel");
    check_eq("lu_rel_ctl", 32'({bus.reg_write, bus.ALU_op}), 32'b1_010);
    advance();

    // Branch taken.
    write_reg(1, 32'd5);
    write_reg(2, 32'd5);
    set_idle();
    bus.instr    = itype(6'b000100, 1, 2, 16'hFFFE);
    bus.pc_plus4 = 32'h40;
    settle("bt");
    check_eq("bt_taken", 32'({bus.branch_taken, bus.if_id_flush}), 32'b11);
    check_eq("bt_target", bus.branch_target, 32'h38);
    advance();

    // Load followed by beq: two stall cycles, then not taken.
    write_reg(3, 32'd4);
    set_idle();
    bus.instr           = itype(6'b000100, 3, 0, 16'h0003);
    bus.id_ex_mem_read  = 1'b1;
    bus.id_ex_reg_write = 1'b1;
    bus.ex_write_reg    = 5'd3;
    settle("bl1");
    check_eq("bl1_pc_write", 32'(bus.pc_write), 32'd0);
    advance();
    bus.id_ex_mem_read   = 1'b0;
    bus.id_ex_reg_write  = 1'b0;
    bus.ex_write_reg     = 5'd0;
    bus.ex_mem_mem_read  = 1'b1;
    bus.ex_mem_write_reg = 5'd3;
    settle("bl2");
    check_eq("bl2_pc_write", 32'(bus.pc_write), 32'd0);
    advance();
    bus.ex_mem_mem_read  = 1'b0;
    bus.ex_mem_write_reg = 5'd0;
    settle("bl3");
    check_eq("bl3_flow", 32'({bus.pc_write, bus.branch_taken}), 32'b10);
    advance();

    // Unknown opcode.
    set_idle();
    bus.instr = {6'b111111, 26'h2A5_5A5A};
    settle("unk");
    check_eq("unk_ctl", 32'({bus.mem_write, bus.mem_read, bus.reg_write, bus.reg_dst,
                             bus.mem_to_reg, bus.ALU_src, bus.ALU_op}), 32'd0);
    check_eq("unk_pc_write", 32'(bus.pc_write), 32'd1);
    advance();

    // Random traffic over a small register window so hazards and equal
    // operands occur often.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b001000;
        4: op = 6'b001100;
        5: op = 6'b000100;
        default: op = 6'($urandom_range(0, 63));
      endcase
      rst                  = ($urandom_range(0, 49) != 0);
      bus.instr            = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)), 11'($urandom)};
      bus.pc_plus4         = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      bus.wb_reg_write     = ($urandom_range(0, 1) == 1);
      bus.wb_write_reg     = 5'($urandom_range(0, 7));
      bus.wb_write_data    = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      bus.id_ex_mem_read   = ($urandom_range(0, 3) == 0);
      bus.id_ex_reg_write  = ($urandom_range(0, 2) == 0);
      bus.ex_write_reg     = 5'($urandom_range(0, 7));
      bus.ex_mem_mem_read  = ($urandom_range(0, 3) == 0);
      bus.ex_mem_write_reg = 5'($urandom_range(0, 7));
      settle("rnd");
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
